// File: rtl/ycc_bitstream_merge_if.sv
// Channel inputs and merged-output bundle for the
// Y/Cb/Cr bitstream merger.
interface ycc_bitstream_merge_if;
  logic [31:0] y_JPEG_bitstream;
  logic [31:0] cb_JPEG_bitstream;
  logic [31:0] cr_JPEG_bitstream;
  logic        y_data_ready;
  logic        cb_data_ready;
  logic        cr_data_ready;
  logic        y_eob;
  logic        cb_eob;
  logic        cr_eob;
  logic [4:0]  y_orc;
  logic [4:0]  cb_orc;
  logic [4:0]  cr_orc;
  logic        end_of_file_signal;
  logic [31:0] JPEG_bitstream;
  logic        data_ready;
  logic [4:0]  eof_bitstream_count;
  logic        eof_data_partial_ready;
  logic        overflow;

  modport master (
    output y_JPEG_bitstream, cb_JPEG_bitstream, cr_JPEG_bitstream,
    output y_data_ready, cb_data_ready, cr_data_ready,
    output y_eob, cb_eob, cr_eob,
    output y_orc, cb_orc, cr_orc,
    output end_of_file_signal,
    input  JPEG_bitstream, data_ready, eof_bitstream_count,
    input  eof_data_partial_ready, overflow
  );

  modport slave (
    input  y_JPEG_bitstream, cb_JPEG_bitstream, cr_JPEG_bitstream,
    input  y_data_ready, cb_data_ready, cr_data_ready,
    input  y_eob, cb_eob, cr_eob,
    input  y_orc, cb_orc, cr_orc,
    input  end_of_file_signal,
    output JPEG_bitstream, data_ready, eof_bitstream_count,
    output eof_data_partial_ready, overflow
  );
endinterface

// File: rtl/ycc_bitstream_merge.sv
// Merges Y/Cb/Cr Huffman streams into one MSB-first
// 32-bit scan bitstream in Y,Cb,Cr block order.
module ycc_bitstream_merge #(
  parameter int FIFO_DEPTH = 32,
  parameter int FIFO_AW    = 5
) (
  input logic clk,
  input logic rst,
  ycc_bitstream_merge_if.slave bus
);
  // entry = {eob, cnt[5:0], data[31:0]}
  localparam int EW = 39;

  typedef enum logic [1:0] {S_Y, S_CB, S_CR} state_t;

  state_t r_state, w_state_nxt;

  logic [2:0][31:0]   w_in_data;
  logic [2:0][4:0]    w_in_orc;
  logic [2:0]         w_in_dr;
  logic [2:0]         w_in_eob;
  logic [2:0]         w_push;
  logic [2:0]         w_full;
  logic [2:0]         w_empty;
  logic [2:0]         w_pop;
  logic [2:0][EW-1:0] w_rdata;

  assign w_in_data = {bus.cr_JPEG_bitstream,
                      bus.cb_JPEG_bitstream,
                      bus.y_JPEG_bitstream};
  assign w_in_orc  = {bus.cr_orc, bus.cb_orc, bus.y_orc};
  assign w_in_dr   = {bus.cr_data_ready,
                      bus.cb_data_ready,
                      bus.y_data_ready};
  assign w_in_eob  = {bus.cr_eob, bus.cb_eob, bus.y_eob};

  for (genvar c = 0; c < 3; c++) begin : g_fifo
    logic [EW-1:0]    r_mem [FIFO_DEPTH];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic [EW-1:0]    w_wdata;
    logic             w_wr;

    assign w_push[c] = w_in_dr[c] | w_in_eob[c];
    assign w_wr      = w_push[c] & ~w_full[c];
    assign w_wdata   = w_in_eob[c]
                     ? {1'b1, 1'b0, w_in_orc[c], w_in_data[c]}
                     : {1'b0, 6'd32, w_in_data[c]};
    assign w_empty[c] = (r_wptr == r_rptr);
    assign w_full[c]  =
      (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
      (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
    assign w_rdata[c] = r_mem[r_rptr[FIFO_AW-1:0]];

    // channel FIFO pointers; reset empties the FIFO
    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_wr)     r_wptr <= r_wptr + 1'b1;
        if (w_pop[c]) r_rptr <= r_rptr + 1'b1;
      end
    end

    // channel FIFO storage
    always_ff @(posedge clk) begin
      if (!rst && w_wr) r_mem[r_wptr[FIFO_AW-1:0]] <= w_wdata;
    end
  end

  logic [1:0]    w_sel;
  logic [EW-1:0] w_pdata;
  logic          w_pop_any;

  // channel served by the current block state
  always_comb begin
    w_sel = 2'd0;
    unique case (r_state)
      S_Y:     w_sel = 2'd0;
      S_CB:    w_sel = 2'd1;
      S_CR:    w_sel = 2'd2;
      default: w_sel = 2'd0;
    endcase
  end

  // pop one entry per cycle from the current channel
  always_comb begin
    w_pdata   = w_rdata[0];
    w_pop_any = 1'b0;
    w_pop     = 3'b000;
    unique case (w_sel)
      2'd1:    w_pdata = w_rdata[1];
      2'd2:    w_pdata = w_rdata[2];
      default: w_pdata = w_rdata[0];
    endcase
    w_pop_any = ~w_empty[w_sel];
    if (w_pop_any) w_pop = 3'b001 << w_sel;
  end

  // advance block state when an end-of-block entry leaves
  always_comb begin
    w_state_nxt = r_state;
    if (w_pop_any && w_pdata[38]) begin
      unique case (r_state)
        S_Y:     w_state_nxt = S_CB;
        S_CB:    w_state_nxt = S_CR;
        S_CR:    w_state_nxt = S_Y;
        default: w_state_nxt = S_Y;
      endcase
    end
  end

  // block state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_Y;
    else     r_state <= w_state_nxt;
  end

  logic [63:0] r_acc;
  logic [5:0]  r_acc_cnt;
  logic        r_flush_pending;
  logic [31:0] r_data;
  logic        r_dr;
  logic [4:0]  r_eof_cnt;
  logic        r_part;
  logic        r_ovf;

  logic        w_emit;
  logic        w_flush;
  logic [63:0] w_acc1;
  logic [63:0] w_acc_nxt;
  logic [5:0]  w_cnt1;
  logic [5:0]  w_cnt_nxt;
  logic [5:0]  w_pcnt;
  logic [31:0] w_pbits;
  logic [31:0] w_flush_word;

  // drain a full word, then append the popped bits behind the residue
  always_comb begin
    w_emit    = r_acc_cnt[5];
    w_acc1    = w_emit ? {r_acc[31:0], 32'd0} : r_acc;
    w_cnt1    = {1'b0, r_acc_cnt[4:0]};
    w_pcnt    = w_pop_any ? w_pdata[37:32] : 6'd0;
    w_pbits   = w_pdata[31:0] & ~(32'hFFFF_FFFF >> w_pcnt);
    if (!w_pop_any) w_pbits = 32'd0;
    w_acc_nxt = w_acc1 | ({w_pbits, 32'd0} >> w_cnt1);
    w_cnt_nxt = w_cnt1 + w_pcnt;
    w_flush   = r_flush_pending && (r_state == S_Y) &&
                (&w_empty) && !r_acc_cnt[5];
    w_flush_word = r_acc[63:32] |
                   (32'hFFFF_FFFF >> r_acc_cnt[4:0]);
  end

  // accumulator, output words, EOF flush and overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc           <= '0;
      r_acc_cnt       <= '0;
      r_flush_pending <= 1'b0;
      r_data          <= '0;
      r_dr            <= 1'b0;
      r_eof_cnt       <= '0;
      r_part          <= 1'b0;
      r_ovf           <= 1'b0;
    end else begin
      r_dr   <= 1'b0;
      r_part <= 1'b0;
      if (w_flush) begin
        r_data          <= w_flush_word;
        r_eof_cnt       <= r_acc_cnt[4:0];
        r_part          <= 1'b1;
        r_acc           <= '0;
        r_acc_cnt       <= '0;
        r_flush_pending <= 1'b0;
      end else begin
        if (w_emit) begin
          r_data <= r_acc[63:32];
          r_dr   <= 1'b1;
        end
        r_acc     <= w_acc_nxt;
        r_acc_cnt <= w_cnt_nxt;
        if (bus.end_of_file_signal) r_flush_pending <= 1'b1;
      end
      if (|(w_push & w_full)) r_ovf <= 1'b1;
    end
  end

  assign bus.JPEG_bitstream         = r_data;
  assign bus.data_ready             = r_dr;
  assign bus.eof_bitstream_count    = r_eof_cnt;
  assign bus.eof_data_partial_ready = r_part;
  assign bus.overflow               = r_ovf;
endmodule
